// File: rtl/fsm_arb_pkg.sv
// Shared types and constants for the fsm conversion-unit arbiter.
package fsm_arb_pkg;

    localparam int WORD_W   = 16;
    localparam int RESULT_W = 32;

    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SEND0,
        SEND1,
        WAIT,
        RESP
    } arb_state_e;

endpackage

// File: rtl/fsm_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic            valid
);

    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fsm_arbiter.sv
// Round-robin arbiter sequencing NREQ requesters onto one fsm conversion unit.
// Optional WAIT watchdog enabled by defining FSM_ARB_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | no transaction; grant winner (req_ready is Mealy here)
//   SEND0 | strobe word0 into the unit
//   SEND1 | strobe word1 into the unit
//   WAIT  | wait for u_r_o (or watchdog expiry)
//   RESP  | pulse resp_valid to the granted requester, advance rr_ptr
module fsm_arbiter
    import fsm_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*WORD_W-1:0] req_word0,
    input  logic [NREQ*WORD_W-1:0] req_word1,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        resp_valid,
    output logic [RESULT_W-1:0]    resp_data,
    output logic [1:0]             resp_err,
    output logic                   u_reset,
    output logic                   u_R_I,
    output logic [WORD_W-1:0]      u_dataIn,
    input  logic [RESULT_W-1:0]    u_dataOut,
    input  logic                   u_r_o,
    input  logic [1:0]             u_err
);

    localparam int PW = $clog2(NREQ);

    arb_state_e          state_q, state_d;
    logic [PW-1:0]       ptr_q, gidx_q, pick_idx;
    logic [NREQ-1:0]     gnt_q, pick_grant;
    logic                pick_valid;
    logic [WORD_W-1:0]   word1_q, pick_w0, pick_w1;
    logic                ri_q;
    logic [WORD_W-1:0]   din_q;
    logic [NREQ-1:0]     rv_q;
    logic [RESULT_W-1:0] rd_q;
    logic [1:0]          re_q;
    logic                tmo_tc;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        pick_w0  = '0;
        pick_w1  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_grant[i]) begin
                pick_idx = PW'(i);
                pick_w0  = req_word0[WORD_W*i +: WORD_W];
                pick_w1  = req_word1[WORD_W*i +: WORD_W];
            end
        end
    end

`ifdef FSM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmr_q;
    logic          tmo_pulse_q;

    // Reloaded whenever outside WAIT, so it always starts fresh on entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_q       <= '0;
            tmo_pulse_q <= 1'b0;
        end else begin
            if (state_q != WAIT)
                tmr_q <= TW'(TIMEOUT - 1);
            else if (tmr_q != '0)
                tmr_q <= tmr_q - TW'(1);
            tmo_pulse_q <= (state_q == WAIT) && tmo_tc && !u_r_o;
        end
    end

    assign tmo_tc  = (tmr_q == '0);
    assign u_reset = reset | tmo_pulse_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign tmo_tc         = 1'b0;
    assign u_reset        = reset;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = SEND0;
            SEND0:   state_d = SEND1;
            SEND1:   state_d = WAIT;
            WAIT:    if (u_r_o || tmo_tc) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE && !reset) ? pick_grant : '0;

    // Outputs are registered from the next state so they are glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            gnt_q   <= '0;
            word1_q <= '0;
            ri_q    <= 1'b0;
            din_q   <= '0;
            rv_q    <= '0;
            rd_q    <= '0;
            re_q    <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE && pick_valid) begin
                gnt_q   <= pick_grant;
                gidx_q  <= pick_idx;
                word1_q <= pick_w1;
            end

            ri_q <= (state_d == SEND0) || (state_d == SEND1);
            case (state_d)
                SEND0:   din_q <= pick_w0;
                SEND1:   din_q <= word1_q;
                default: din_q <= '0;
            endcase

            rv_q <= (state_d == RESP) ? gnt_q : '0;
            if (state_d == RESP && state_q == WAIT) begin
                rd_q <= u_r_o ? u_dataOut : '0;
                re_q <= u_r_o ? u_err : ERR_TIMEOUT;
            end else begin
                rd_q <= '0;
                re_q <= '0;
            end

            if (state_q == RESP)
                ptr_q <= (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);
        end
    end

    assign u_R_I      = ri_q;
    assign u_dataIn   = din_q;
    assign resp_valid = rv_q;
    assign resp_data  = rd_q;
    assign resp_err   = re_q;

endmodule

// File: doc/fsm_arbiter.md
# fsm_arbiter

Round-robin arbiter and sequencer that shares one `fsm` conversion unit among `NREQ` requesters. Each requester presents a two-word operand pair. The arbiter grants one requester at a time, streams both 16-bit words into the unit over its `R_I`/`dataIn` interface, and waits for the `r_o` completion pulse. It then returns the 32-bit `dataOut` and 2-bit `err` to the granted requester. It sits between the request ports and the single `fsm` instance.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 64: maximum number of WAIT cycles before the unit is declared hung. Used only with `FSM_ARB_TIMEOUT_EN`.
- `clk` input, 1 bit: single clock; all logic on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `req_valid` input, `NREQ` bits: per-requester request pending.
- `req_word0` input, `NREQ*16` bits: first operand word; requester i uses bits [16i+15:16i].
- `req_word1` input, `NREQ*16` bits: second operand word, packed the same way.
- `req_ready` output, `NREQ` bits: one-hot acceptance pulse for the granted requester.
- `resp_valid` output, `NREQ` bits: one-hot result pulse.
- `resp_data` output, 32 bits: result, shared by all requesters and qualified by `resp_valid`.
- `resp_err` output, 2 bits: error code, qualified by `resp_valid`.
- `u_reset` output, 1 bit: reset to the unit.
- `u_R_I` output, 1 bit: word strobe to the unit.
- `u_dataIn` output, 16 bits: word to the unit.
- `u_dataOut` input, 32 bits: unit result.
- `u_r_o` input, 1 bit: unit completion pulse.
- `u_err` input, 2 bits: unit error code.

## Operation
- **States:** IDLE, SEND0, SEND1, WAIT, RESP.
- **IDLE:**
  - If any `req_valid` is set, pick winner `g` as the first set bit at or after `rr_ptr`, wrapping modulo `NREQ`.
  - Latch `req_word0[g]` and `req_word1[g]` into internal registers and pulse `req_ready[g]`.
  - Go to SEND0.
  - The requester may drop or change its inputs after `req_ready`.
- **SEND0:** `u_R_I`=1, `u_dataIn`=word0. Go to SEND1.
- **SEND1:** `u_R_I`=1, `u_dataIn`=word1. Go to WAIT.
- **WAIT:**
  - `u_R_I`=0, `u_dataIn`=0.
  - On `u_r_o`=1, capture `u_dataOut` and `u_err`, then go to RESP.
  - A `u_r_o` seen in SEND0 or SEND1 is ignored.
- **RESP:**
  - Pulse `resp_valid[g]` with the captured data and error.
  - Set `rr_ptr` to (g+1) mod `NREQ`.
  - Go to IDLE.
- **Single outstanding transaction:** only one transaction is in flight. `req_valid` from other requesters is held off with no `req_ready` until the arbiter is back in IDLE.
- **Simultaneous requests:** strictly round-robin. A requester that stays valid is served at most once per `NREQ` grants.
- **Fairness boundary:** when `rr_ptr` points at a non-requesting index, the scan wraps, e.g. `rr_ptr`=3, valid=4'b0011 gives grant 0.
- **Reset:**
  - Everything returns to IDLE; `rr_ptr`=0.
  - All outputs are 0 except `u_reset`, which follows `reset` combinationally OR the timeout pulse.
  - On reset mid-transaction the in-flight transaction is dropped with no `resp_valid`.

## Timing
- Request to `req_ready`: same cycle the arbiter is in IDLE with `req_valid` set (Mealy).
- First `u_R_I` is 1 cycle after `req_ready`; the two `u_R_I` cycles are back-to-back.
- `resp_valid` asserts 1 cycle after the `u_r_o` cycle.
- **Minimum turnaround**, with `u_r_o` in the first WAIT cycle: `req_ready` at cycle t, SEND0 t+1, SEND1 t+2, WAIT t+3, RESP t+4, next grant t+5.
- All registered outputs are glitch-free; only `req_ready` is combinational from state and `req_valid`.

## Configuration
- `FSM_ARB_TIMEOUT_EN` defined:
  - WAIT counts cycles.
  - When the count reaches `TIMEOUT` with no `u_r_o`, go to RESP with `resp_err`=2'b11 and `resp_data`=0.
  - Pulse `u_reset` for exactly 1 cycle, in the RESP cycle.
  - The counter clears on entry to WAIT.
- `FSM_ARB_TIMEOUT_EN` undefined:
  - WAIT waits indefinitely.
  - No counter logic is present.
  - `u_reset` equals `reset`.

## Structure
- **Shared package `fsm_arb_pkg`:** state enum (IDLE, SEND0, SEND1, WAIT, RESP), `ERR_TIMEOUT`=2'b11, word width 16, result width 32.
- **Sub-module `rr_pick`:** combinational round-robin picker taking `req`[NREQ] and `ptr` and producing a one-hot `grant` plus a `valid` flag. It is reused by other shared-resource arbiters.

## Test plan
- **Single request:** requester 1 sends word0=16'h40A0, word1=16'h0000, and the unit model returns `r_o` 2 cycles after SEND1 with `dataOut`=32'h40A00000, `err`=0. Expect `u_dataIn` sequence 40A0 then 0000, then `resp_valid`=4'b0010 with matching data, and `rr_ptr`=2.
- **All four requesters valid from reset:** grants occur in order 0, 1, 2, 3, 0. No requester is granted twice before the others are served.
- **Wrap:** with `rr_ptr`=3 and valid=4'b0011, expect grant 0.
- **Error passthrough:** the unit returns `err`=2'b01 with word pair 40E0/0000. Expect `resp_err`=2'b01 on the correct requester.
- **Reset asserted during WAIT:** expect no `resp_valid`, all outputs 0 the next cycle, and the next grant starting at requester 0.
- **With `FSM_ARB_TIMEOUT_EN` and `TIMEOUT`=8:** the unit never pulses `r_o`. Expect `resp_valid` 9 cycles after SEND1 with `resp_err`=2'b11 and `resp_data`=0, plus a 1-cycle `u_reset` pulse.
